// File: rtl/cnt_arbiter_pkg.sv
// Shared constants and types for the two-requester counter arbiter.
package cnt_arbiter_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 2;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_LOAD = 2'b00;
  localparam op_t OP_UP   = 2'b01;
  localparam op_t OP_DOWN = 2'b10;
  localparam op_t OP_NOP  = 2'b11;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Round-robin pick: true selects requester B.
  function automatic logic pick_b(input logic req_a, input logic req_b, input logic prio_b);
    return (req_a && req_b) ? prio_b : req_b;
  endfunction

endpackage

// File: rtl/cnt_arbiter_if.sv
// Requester-side bundle of the counter arbiter: requests, grants, completions and counter status.
interface cnt_arbiter_if #(
  parameter int unsigned WIDTH = 5
);
  import cnt_arbiter_pkg::*;

  logic             req_a;
  logic             req_b;
  op_t              op_a;
  op_t              op_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             done_a;
  logic             done_b;
  logic             sat;
  logic             busy;
  logic             owner;
  logic [WIDTH-1:0] count;
  logic             high;
  logic             low;

  modport master (
    output req_a, req_b, op_a, op_b, data_a, data_b,
    input  gnt_a, gnt_b, done_a, done_b, sat, busy, owner, count, high, low
  );

  modport slave (
    input  req_a, req_b, op_a, op_b, data_a, data_b,
    output gnt_a, gnt_b, done_a, done_b, sat, busy, owner, count, high, low
  );

endinterface

// File: rtl/cnt_arbiter_updn_core.sv
// Saturating up/down counter datapath with load and bound flags.
module updn_core #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             high,
  output logic             low
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  assign high = (count == CNT_MAX);
  assign low  = (count == '0);

  // Steps at a bound are dropped so the value never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (inc && !high) begin
      count <= count + WIDTH'(1);
    end else if (dec && !low) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/cnt_arbiter.sv
// Round-robin arbiter granting two requesters exclusive LOAD/UP/DOWN/NOP access to a shared counter.
module cnt_arbiter
  import cnt_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  cnt_arbiter_if.slave  bus
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             owner_q, owner_d;
  logic             prio_b_q, prio_b_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic             sat_q, sat_d;
  logic             busy_q, busy_d;

  logic             load_c, inc_c, dec_c;
  logic             finish_c;
  logic             sel_b_c;
  logic [WIDTH-1:0] count;
  logic             high, low;

  updn_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .inc   (inc_c),
    .dec   (dec_c),
    .din   (data_q),
    .count (count),
    .high  (high),
    .low   (low)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      data_q   <= '0;
      owner_q  <= 1'b0;
      prio_b_q <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      owner_q  <= owner_d;
      prio_b_q <= prio_b_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
    end
  end

  // Next state, datapath enables and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    owner_d  = owner_q;
    prio_b_d = prio_b_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    sat_d    = 1'b0;
    load_c   = 1'b0;
    inc_c    = 1'b0;
    dec_c    = 1'b0;
    finish_c = 1'b0;
    sel_b_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_a || bus.req_b) begin
          sel_b_c = pick_b(bus.req_a, bus.req_b, prio_b_q);
          owner_d = sel_b_c;
          op_d    = sel_b_c ? bus.op_b : bus.op_a;
          data_d  = sel_b_c ? bus.data_b : bus.data_a;
          gnt_a_d = !sel_b_c;
          gnt_b_d = sel_b_c;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // data_q doubles as the remaining-step counter for UP/DOWN.
        case (op_q)
          OP_LOAD: begin
            load_c   = 1'b1;
            finish_c = 1'b1;
          end
          OP_UP: begin
            if (data_q == '0) begin
              finish_c = 1'b1;
            end else if (high) begin
              finish_c = 1'b1;
              sat_d    = 1'b1;
            end else begin
              inc_c    = 1'b1;
              data_d   = data_q - WIDTH'(1);
              finish_c = (data_q == WIDTH'(1));
            end
          end
          OP_DOWN: begin
            if (data_q == '0) begin
              finish_c = 1'b1;
            end else if (low) begin
              finish_c = 1'b1;
              sat_d    = 1'b1;
            end else begin
              dec_c    = 1'b1;
              data_d   = data_q - WIDTH'(1);
              finish_c = (data_q == WIDTH'(1));
            end
          end
          default: finish_c = 1'b1;
        endcase

        if (finish_c) begin
          state_d  = ST_DONE;
          done_a_d = !owner_q;
          done_b_d = owner_q;
        end
      end

      ST_DONE: begin
        prio_b_d = !owner_q;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.gnt_a  = gnt_a_q;
  assign bus.gnt_b  = gnt_b_q;
  assign bus.done_a = done_a_q;
  assign bus.done_b = done_b_q;
  assign bus.sat    = sat_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;
  assign bus.count  = count;
  assign bus.high   = high;
  assign bus.low    = low;

endmodule

// File: tb/tb_cnt_arbiter.sv
// Self-checking bench for cnt_arbiter: vector table, scoreboard on done pulses, reset and round-robin sequences.
module tb_cnt_arbiter;
  import cnt_arbiter_pkg::*;

  localparam int unsigned WIDTH = 5;

  typedef struct {
    logic             side;
    logic [WIDTH-1:0] cnt;
    logic             sat;
  } exp_t;

  typedef struct {
    logic             side;
    op_t              op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] cnt;
    logic             sat;
    logic             high;
    logic             low;
    int               cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnt_arbiter_if #(.WIDTH(WIDTH)) bus();

  cnt_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sbq[$];
  int   checks     = 0;
  int   errors     = 0;
  int   dones_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.done_a || bus.done_b)) begin
      dones_seen++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_a=%0b done_b=%0b expected no done", bus.done_a, bus.done_b);
      end else begin
        e = sbq.pop_front();
        chk("done_owner", int'(bus.done_b), int'(e.side));
        chk("done_onehot", int'(bus.done_a) + int'(bus.done_b), 1);
        chk("done_count", int'(bus.count), int'(e.cnt));
        chk("done_sat", int'(bus.sat), int'(e.sat));
      end
    end
  end

  task automatic drive(input logic side, input logic req, input op_t op, input logic [WIDTH-1:0] data);
    if (side) begin
      bus.req_b = req; bus.op_b = op; bus.data_b = data;
    end else begin
      bus.req_a = req; bus.op_a = op; bus.data_a = data;
    end
  endtask

  task automatic wait_gnt(input logic side, input string name);
    int n = 0;
    while (!(side ? bus.gnt_b : bus.gnt_a) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(side ? bus.gnt_b : bus.gnt_a), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.busy), 0);
  endtask

  // One complete operation from an idle arbiter; called just after a falling edge.
  task automatic issue(input vec_t v, input string name);
    int cyc = 0;
    exp_t e;
    e.side = v.side; e.cnt = v.cnt; e.sat = v.sat;
    sbq.push_back(e);
    drive(v.side, 1'b1, v.op, v.data);
    wait_gnt(v.side, {name, "_gnt"});
    // Garbage on op/data after grant must not disturb the latched operation.
    drive(v.side, 1'b0, op_t'($urandom_range(3)), WIDTH'($urandom));
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk({name, "_cycles"}, cyc, v.cyc);
    chk({name, "_pending"}, sbq.size(), 0);
    chk({name, "_high"}, int'(bus.high), int'(v.high));
    chk({name, "_low"}, int'(bus.low), int'(v.low));
  endtask

  vec_t vt[12];
  vec_t v0;
  int   d0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.op_a = OP_NOP; bus.op_b = OP_NOP;
    bus.data_a = '0; bus.data_b = '0;
    rst_n = 1'b0;

    // {side, op, data, count, sat, high, low, busy cycles}
    vt[0]  = '{1'b0, OP_LOAD, 5'd28, 5'd28, 1'b0, 1'b0, 1'b0, 2};
    vt[1]  = '{1'b1, OP_UP,   5'd5,  5'd31, 1'b1, 1'b1, 1'b0, 5};
    vt[2]  = '{1'b0, OP_DOWN, 5'd3,  5'd28, 1'b0, 1'b0, 1'b0, 4};
    vt[3]  = '{1'b1, OP_LOAD, 5'd3,  5'd3,  1'b0, 1'b0, 1'b0, 2};
    vt[4]  = '{1'b0, OP_DOWN, 5'd0,  5'd3,  1'b0, 1'b0, 1'b0, 2};
    vt[5]  = '{1'b1, OP_NOP,  5'd9,  5'd3,  1'b0, 1'b0, 1'b0, 2};
    vt[6]  = '{1'b0, OP_DOWN, 5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5};
    vt[7]  = '{1'b1, OP_UP,   5'd2,  5'd2,  1'b0, 1'b0, 1'b0, 3};
    vt[8]  = '{1'b0, OP_UP,   5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 31};
    vt[9]  = '{1'b1, OP_DOWN, 5'd31, 5'd0,  1'b0, 1'b0, 1'b1, 32};
    vt[10] = '{1'b0, OP_LOAD, 5'd31, 5'd31, 1'b0, 1'b1, 1'b0, 2};
    vt[11] = '{1'b1, OP_UP,   5'd0,  5'd31, 1'b0, 1'b1, 1'b0, 2};

    // Reset values
    #12;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_low", int'(bus.low), 1);
    chk("rst_high", int'(bus.high), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_gnt", int'(bus.gnt_a) + int'(bus.gnt_b), 0);
    chk("rst_done", int'(bus.done_a) + int'(bus.done_b), 0);
    chk("rst_sat", int'(bus.sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 7 from idle, cycle by cycle
    v0 = '{1'b0, OP_LOAD, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 2};
    sbq.push_back('{1'b0, 5'd7, 1'b0});
    drive(1'b0, 1'b1, OP_LOAD, 5'd7);
    @(negedge clk);
    chk("l7_gnt_a", int'(bus.gnt_a), 1);
    chk("l7_gnt_b", int'(bus.gnt_b), 0);
    chk("l7_busy", int'(bus.busy), 1);
    chk("l7_count_before", int'(bus.count), 0);
    drive(1'b0, 1'b0, OP_UP, 5'd30);
    @(negedge clk);
    chk("l7_count", int'(bus.count), int'(v0.cnt));
    chk("l7_done_a", int'(bus.done_a), 1);
    chk("l7_gnt_off", int'(bus.gnt_a), 0);
    @(negedge clk);
    chk("l7_idle", int'(bus.busy), 0);
    chk("l7_done_off", int'(bus.done_a), 0);

    for (int i = 0; i < 12; i++) begin
      issue(vt[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of an UP run abandons it
    issue('{1'b0, OP_LOAD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2}, "clr");
    drive(1'b1, 1'b1, OP_UP, 5'd20);
    wait_gnt(1'b1, "mid_gnt");
    drive(1'b1, 1'b0, OP_NOP, 5'd0);
    repeat (3) @(negedge clk);
    chk("mid_count_moving", int'(bus.count), 3);
    d0 = dones_seen;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_low", int'(bus.low), 1);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_owner", int'(bus.owner), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_no_done", dones_seen, d0);
    chk("mid_count_held", int'(bus.count), 0);

    // Both requesters high continuously: A first after reset, then alternate
    drive(1'b0, 1'b1, OP_LOAD, 5'd1);
    drive(1'b1, 1'b1, OP_LOAD, 5'd2);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      logic es;
      es = (k % 2) == 1;
      sbq.push_back('{es, es ? 5'd2 : 5'd1, 1'b0});
      while (!(bus.gnt_a || bus.gnt_b) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("rr%0d_gnt_b", k), int'(bus.gnt_b), int'(es));
      chk($sformatf("rr%0d_gnt_one", k), int'(bus.gnt_a) + int'(bus.gnt_b), 1);
      if (k == 3) begin
        drive(1'b0, 1'b0, OP_NOP, 5'd0);
        drive(1'b1, 1'b0, OP_NOP, 5'd0);
      end
      wait_idle($sformatf("rr%0d_idle", k));
    end
    repeat (3) @(negedge clk);
    chk("rr_pending", sbq.size(), 0);
    chk("rr_final_count", int'(bus.count), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_arbiter.md
CNT_ARBITER -- requirements
Module: cnt_arbiter

Interface
REQ-001 Parameter: WIDTH, default 5, counter width in bits (all verification values assume 5).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_a / req_b  input  1 each  request from requester A / B; held until granted.
REQ-005 op_a / op_b  input  2 each  operation: 00 LOAD, 01 UP, 10 DOWN, 11 NOP; sampled at grant.
REQ-006 data_a / data_b  input  WIDTH each  load value (LOAD) or step count (UP/DOWN); sampled at grant.
REQ-007 gnt_a / gnt_b  output  1 each  one-cycle grant pulse to the selected requester.
REQ-008 done_a / done_b  output  1 each  one-cycle completion pulse to the owning requester.
REQ-009 sat  output  1  valid with done; 1 = the operation stopped early at a bound.
REQ-010 busy  output  1  high in any state except IDLE.
REQ-011 owner  output  1  current or last owner (0 = A, 1 = B).
REQ-012 count  output  WIDTH  shared counter value.
REQ-013 high / low  output  1 each  count == 2^WIDTH-1 / count == 0; combinational from count.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE: if any req is high, the FSM SHALL select one requester, latch its op/data, and assert its gnt for exactly the next cycle while entering RUN.
REQ-016 Arbitration SHALL be round-robin: if both requesters are high, grant the one that did not own the last completed operation; after reset, A wins.
REQ-017 Grant latency SHALL be 1 cycle: req sampled high in IDLE at edge N -> gnt high in cycle N+1.
REQ-018 LOAD: in the first RUN cycle, count SHALL take data at the end of that cycle; then DONE with sat=0.
REQ-019 UP/DOWN: each RUN cycle SHALL add or subtract 1 and decrement the remaining-steps counter.
REQ-020 UP/DOWN SHALL enter DONE when the remaining steps reach 0.
REQ-021 Bound rule: a step that would pass 2^WIDTH-1 (UP) or 0 (DOWN) SHALL NOT be applied; the FSM SHALL enter DONE with sat=1.
REQ-022 The counter SHALL never wrap around.
REQ-023 Step count 0 or NOP SHALL spend one RUN cycle with count unchanged, then DONE with sat=0.
REQ-024 DONE SHALL last exactly one cycle, pulse the owner's done, update the round-robin pointer, and return to IDLE.
REQ-025 Requests arriving during RUN/DONE SHALL wait.
REQ-026 A req still high in IDLE after done SHALL count as a new request.
REQ-027 Changes on op/data after grant SHALL have no effect.
REQ-028 The count SHALL be written only by the FSM.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, count 0, and gnt_*, done_*, sat, busy, owner all 0.
REQ-030 While rst_n is low: low=1, high=0, and the round-robin pointer favours A.
REQ-031 Reset asserted mid-operation SHALL abandon the operation; no done pulse is issued.

Structure
REQ-032 A shared package SHALL hold the op encoding constants (OP_LOAD, OP_UP, OP_DOWN, OP_NOP) and the FSM state typedef.
REQ-033 The counter datapath SHALL be one sub-module, updn_core (load / inc / dec enables, saturating bounds, high/low flags); the FSM and arbiter stay in cnt_arbiter.

Verification
REQ-034 Reset mid-RUN: reset asserted during an UP run -> count=0, low=1, busy=0 at once; no done pulse.
REQ-035 req_a LOAD data=7 from idle -> gnt_a in cycle 1, count=7 after cycle 2, done_a in cycle 3, sat=0.
REQ-036 Count=28, req_b UP data=5 -> count 29,30,31 then done_b with sat=1, count stays 31, high=1.
REQ-037 req_a and req_b high together from reset -> A granted first, B granted in the IDLE after done_a; repeated both-high requests alternate A,B,A,B.
REQ-038 Count=3, DOWN data=0 and then NOP -> each gives done after one RUN cycle, count stays 3, sat=0.
